lvds_pixel_packer: RTL and testbench
====================================

LVDS_PIXEL_PACKER -- requirements
Module: lvds_pixel_packer

Interface
REQ-001 SHALL have parameter DW, default 15: sample width in bits; legal values 1..15.
REQ-002 SHALL have parameter PKT_WORDS, default 256: maximum number of 32-bit words per packet; legal values 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries; must be a power of 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: when high, the block packs samples; when low, it flushes and idles.
REQ-007 SHALL have port in_valid, input, 1 bit: qualifies in_data and in_group for one cycle; it arrives already synchronous to clk.
REQ-008 SHALL have port in_data, input, DW bits: the captured LVDS sample.
REQ-009 SHALL have port in_group, input, 1 bit: the group tag of the sample.
REQ-010 SHALL have port m_tdata, output, 32 bits: the packed output word.
REQ-011 SHALL have ports m_tvalid (output, 1 bit), m_tready (input, 1 bit) and m_tlast (output, 1 bit): the AXI-Stream handshake and packet end marker.
REQ-012 SHALL have port m_tuser, output, 2 bits: [0] is start-of-packet (SOP) and [1] is the packet group.
REQ-013 SHALL have port clr_ovf, input, 1 bit: a pulse that clears the overflow flag and drop_cnt.
REQ-014 SHALL have ports overflow (output, 1 bit, sticky drop flag) and drop_cnt (output, 16 bits, count of dropped words).

Function
REQ-015 SHALL pack each word as: [DW-1:0] sample A, [15] valid A, [DW+15:16] sample B, [31] valid B. Unused bits are 0.
REQ-016 SHALL take sample A as the earlier of the two samples in the word.
REQ-017 SHALL implement a packer FSM with three states:
  - IDLE (enable=0);
  - LO (no half-word pending);
  - HI (sample A held).
REQ-018 In LO, a sample with in_valid=1 and enable=1 SHALL be stored as sample A, and the FSM SHALL go to HI.
REQ-019 In HI, a sample with in_valid=1 and the same group SHALL complete the word (valid A = valid B = 1), and the FSM SHALL go to LO.
REQ-020 A close event SHALL be any of:
  - in_valid=1 with in_group different from the current packet group;
  - enable falling while a packet is open.
REQ-021 On a close event in HI, the held sample SHALL form a padded word (valid B=0, sample B=0) that is marked as the last word of the packet.
REQ-022 On a close event caused by a group change, the new sample SHALL be stored as sample A of the next packet, and the FSM SHALL stay in or enter HI.
REQ-023 Each completed word SHALL be loaded into a one-word stage register.
REQ-024 The stage register SHALL be pushed to the FIFO with m_tlast=0 when the next word completes.
REQ-025 The stage register SHALL be pushed with m_tlast=1 in any of these cases:
  - its word index equals PKT_WORDS-1 (pushed in the cycle after loading);
  - it is marked last;
  - a close event finds HI empty with the stage occupied.
REQ-026 When a padded word must follow an occupied stage, the stage SHALL be pushed (tlast=0) in cycle N, the padded word loaded in cycle N, and the padded word pushed with tlast=1 in cycle N+1.
REQ-027 The block SHALL perform at most one FIFO push per cycle.
REQ-028 The first word after reset, after m_tlast, or after enable rising SHALL carry m_tuser[0]=1.
REQ-029 m_tuser[1] SHALL be the group of the packet.
REQ-030 The word index SHALL reset to 0 after every tlast.
REQ-031 The output FIFO SHALL be first-word fall-through: m_tvalid = FIFO not empty, and a pop occurs when m_tvalid and m_tready are both high.
REQ-032 A push into a full FIFO SHALL drop the word, set overflow=1 and increment drop_cnt, saturating at 16'hFFFF. A pop in the same cycle does not free space for that push.
REQ-033 When clr_ovf coincides with a drop, overflow SHALL be 1 and drop_cnt SHALL be 1.
REQ-034 In IDLE, samples SHALL be ignored, and the FIFO SHALL keep draining.

Reset
REQ-035 While rst=1, the FSM SHALL be LO (or IDLE if enable=0), the stage and FIFO SHALL be empty, and the word index and group SHALL be 0.
REQ-036 While rst=1, these outputs SHALL be 0: m_tvalid, m_tdata, m_tlast, m_tuser, overflow, drop_cnt.
REQ-037 Reset mid-packet SHALL discard all partial data, and the first word after reset SHALL carry SOP.

Verification
REQ-038 Bench SHALL cover: group 0, samples 1,2,3,4, then a group-1 sample -> 32'h8002_8001 (SOP=1, tlast=0), then 32'h8004_8003 (tlast=1).
REQ-039 Bench SHALL cover: group 0, samples 1,2,3, then a group-1 sample 5 -> 32'h8002_8001, then 32'h0000_8003 (tlast=1); the next packet begins with sample A=5, SOP=1 and tuser[1]=1.
REQ-040 Bench SHALL cover: PKT_WORDS=4 with 16 continuous samples -> 8 words, tlast on words 4 and 8, SOP on words 1 and 5.
REQ-041 Bench SHALL cover: m_tready=0, FIFO_DEPTH=8, 20 words produced -> 8 words held, overflow=1, drop_cnt=12 (or as computed by the model); clr_ovf -> both 0.
REQ-042 Bench SHALL cover: enable falling in HI with sample 7 -> padded word 32'h0000_8007 with tlast=1; samples ignored until enable rises again.
REQ-043 Bench SHALL cover: rst asserted in HI with the stage occupied -> all outputs 0 immediately; after release, samples 9,10 -> 32'h800A_8009 with SOP=1.

Source files
------------

// File: rtl/lvds_pixel_packer.sv
// Packs pairs of LVDS samples into 32-bit words, frames them into grouped packets
// and buffers them in a first-word fall-through AXI-Stream output FIFO.
module lvds_pixel_packer #(
  parameter int DW         = 15,
  parameter int PKT_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_group,
  output logic [31:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [1:0]    m_tuser,
  input  logic          clr_ovf,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  // state | meaning
  // IDLE  | enable low, samples ignored, stage and FIFO keep draining
  // LO    | packing, no half-word pending
  // HI    | packing, sample A held in hold_a
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(PKT_WORDS - 1);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  state_t        state, nxt_state;
  logic [DW-1:0] hold_a;
  logic          pkt_grp;
  logic [15:0]   word_idx;
  logic          sop_next;
  logic          stage_v, stage_last, stage_sop, stage_grp;
  logic [31:0]   stage_data;

  logic          samp, grp_chg, close_lo, capture_a;
  logic          load, load_last, push, push_last;
  logic [31:0]   load_word;

  function automatic logic [31:0] pack_word(input logic [DW-1:0] a, input logic va,
                                            input logic [DW-1:0] b, input logic vb);
    logic [31:0] w;
    w            = '0;
    w[DW-1:0]    = a;
    w[15]        = va;
    w[DW+15:16]  = b;
    w[31]        = vb;
    return w;
  endfunction

  always_comb begin
    samp      = in_valid && enable;
    grp_chg   = samp && (in_group != pkt_grp);
    nxt_state = state;
    close_lo  = 1'b0;
    capture_a = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    load_word = '0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state)
      HI: begin
        if (!enable || grp_chg) begin
          load      = 1'b1;
          load_word = pack_word(hold_a, 1'b1, '0, 1'b0);
          load_last = 1'b1;
          capture_a = grp_chg;
          nxt_state = grp_chg ? HI : IDLE;
        end else if (samp) begin
          load      = 1'b1;
          load_word = pack_word(hold_a, 1'b1, in_data, 1'b1);
          load_last = (word_idx == LAST_IDX);
          nxt_state = LO;
        end
      end
      default: begin
        close_lo = !enable || grp_chg;
        if (!enable) begin
          nxt_state = IDLE;
        end else if (samp) begin
          capture_a = 1'b1;
          nxt_state = HI;
        end else begin
          nxt_state = LO;
        end
      end
    endcase
    // A loading word always evicts the stage; otherwise the stage only leaves as a packet end
    if (load) begin
      push      = stage_v;
      push_last = stage_last;
    end else if (stage_v && (stage_last || close_lo)) begin
      push      = 1'b1;
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LO;
      hold_a     <= '0;
      pkt_grp    <= 1'b0;
      word_idx   <= '0;
      sop_next   <= 1'b1;
      stage_v    <= 1'b0;
      stage_last <= 1'b0;
      stage_sop  <= 1'b0;
      stage_grp  <= 1'b0;
      stage_data <= '0;
    end else begin
      state <= nxt_state;
      if (capture_a) begin
        hold_a  <= in_data;
        pkt_grp <= in_group;
      end
      if (load) begin
        stage_v    <= 1'b1;
        stage_data <= load_word;
        stage_last <= load_last;
        stage_sop  <= sop_next;
        stage_grp  <= pkt_grp;
        sop_next   <= load_last;
        word_idx   <= load_last ? 16'd0 : word_idx + 16'd1;
      end else begin
        if (push) stage_v <= 1'b0;
        if ((push && push_last) || !enable) begin
          sop_next <= 1'b1;
          word_idx <= '0;
        end
      end
    end
  end

  // Output FIFO: entry = {group, sop, last, data}
  logic [34:0]   mem [FIFO_DEPTH];
  logic [34:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, wr, pop, drop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = !empty && m_tready;
  assign wr    = push && !full;
  assign drop  = push && full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {stage_grp, stage_sop, push_last, stage_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      count <= count + (AW+1)'(1);
      else if (!wr && pop) count <= count - (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)                    drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  assign m_tvalid = !empty;
  assign m_tdata  = empty ? 32'd0 : head[31:0];
  assign m_tlast  = empty ? 1'b0  : head[32];
  assign m_tuser  = empty ? 2'b00 : {head[34], head[33]};

endmodule

// File: tb/tb_lvds_pixel_packer.sv
// Directed bench for lvds_pixel_packer: a transaction-level packing model feeds a
// scoreboard queue that is checked against every word the DUT hands out.
module tb_lvds_pixel_packer;

  localparam int DW         = 15;
  localparam int PKT_WORDS  = 4;
  localparam int FIFO_DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_group = 1'b0;
  logic          m_tready = 1'b1;
  logic          clr_ovf = 1'b0;
  logic [31:0]   m_tdata;
  logic          m_tvalid, m_tlast;
  logic [1:0]    m_tuser;
  logic          overflow;
  logic [15:0]   drop_cnt;

  lvds_pixel_packer #(.DW(DW), .PKT_WORDS(PKT_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_group(in_group), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .clr_ovf(clr_ovf), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // {group, sop, last, data}
  typedef logic [34:0] ent_t;
  ent_t exp_q[$];
  ent_t obs[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  logic          m_held, m_grp, m_sop, m_open;
  logic [DW-1:0] m_a;
  int            m_idx, exp_drop;
  bit            cap_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [DW-1:0] a, input logic va,
                                     input logic [DW-1:0] b, input logic vb);
    logic [31:0] w;
    w           = '0;
    w[DW-1:0]   = a;
    w[15]       = va;
    w[DW+15:16] = b;
    w[31]       = vb;
    return w;
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    m_held = 0; m_grp = 0; m_sop = 1; m_open = 0; m_idx = 0; m_a = '0; exp_drop = 0;
  endfunction

  function automatic void m_emit(input logic [31:0] w, input bit force_last);
    bit last;
    last = force_last || (m_idx == PKT_WORDS - 1);
    if (cap_mode && exp_q.size() >= FIFO_DEPTH) exp_drop++;
    else exp_q.push_back({m_grp, m_sop, last, w});
    m_sop  = last;
    m_idx  = last ? 0 : m_idx + 1;
    m_open = !last;
  endfunction

  // Closing with no held sample retro-marks the newest word as the packet end
  function automatic void m_close();
    ent_t e;
    if (m_held) begin
      m_emit(mk(m_a, 1'b1, '0, 1'b0), 1'b1);
      m_held = 0;
    end else if (m_open && exp_q.size() > 0) begin
      e = exp_q[exp_q.size()-1];
      e[32] = 1'b1;
      exp_q[exp_q.size()-1] = e;
      m_sop = 1; m_idx = 0; m_open = 0;
    end
  endfunction

  function automatic void m_sample(input logic g, input logic [DW-1:0] d);
    if (g != m_grp) begin
      m_close();
      m_grp = g;
    end
    if (m_held) begin
      m_emit(mk(m_a, 1'b1, d, 1'b1), 1'b0);
      m_held = 0;
    end else begin
      m_a = d;
      m_held = 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic g, input int d);
    in_valid = 1'b1;
    in_group = g;
    in_data  = d[DW-1:0];
    if (enable) m_sample(g, d[DW-1:0]);
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_en(input logic v);
    if (enable && !v) m_close();
    enable = v;
    step();
  endtask

  task automatic drain(input string tag);
    int k;
    repeat (3) step();
    for (k = 0; k < 200 && (exp_q.size() != 0 || m_tvalid); k++) step();
    check(tag, {63'd0, (exp_q.size() == 0 && !m_tvalid)}, 64'd1);
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tlast"}, m_tlast, 0);
    check({tag, "_tuser"}, m_tuser, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  always @(negedge clk) begin
    ent_t got;
    if (!rst && m_tvalid && m_tready) begin
      got = {m_tuser[1], m_tuser[0], m_tlast, m_tdata};
      obs.push_back(got);
      if (exp_q.size() == 0) check("word_without_expectation", 64'(exp_q.size()), 64'd1);
      else check("scoreboard_word", got, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    m_reset();
    #1;
    check_rst_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // group change closes a full packet
    base = obs.size();
    send(0, 1); send(0, 2); send(0, 3); send(0, 4); send(1, 6);
    drain("t1_drain");
    check("t1_w0", obs[base],   {3'b010, 32'h8002_8001});
    check("t1_w1", obs[base+1], {3'b001, 32'h8004_8003});

    // group change with a held half-word pads it; next packet starts from the new sample
    base = obs.size();
    send(0, 1); send(0, 2); send(0, 3); send(1, 5); send(1, 11);
    set_en(0);
    drain("t2_drain");
    check("t2_pad6",  obs[base],   {3'b111, 32'h0000_8006});
    check("t2_w0",    obs[base+1], {3'b010, 32'h8002_8001});
    check("t2_pad3",  obs[base+2], {3'b001, 32'h0000_8003});
    check("t2_next",  obs[base+3], {3'b111, 32'h800B_8005});

    // length-limited packets
    set_en(1);
    base = obs.size();
    for (int i = 0; i < 16; i++) send(0, 16 + i);
    drain("t3_drain");
    check("t3_count", obs.size() - base, 8);
    check("t3_w0", obs[base], {3'b010, 32'h8011_8010});
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_last%0d", k), obs[base+k][32], (k % 4 == 3));
      check($sformatf("t3_sop%0d", k),  obs[base+k][33], (k % 4 == 0));
    end

    // back-pressure overflow
    m_tready = 1'b0;
    cap_mode = 1'b1;
    base = obs.size();
    for (int i = 0; i < 40; i++) send(0, i + 1);
    repeat (4) step();
    check("t4_tvalid", m_tvalid, 1);
    check("t4_overflow", overflow, 1);
    check("t4_drop_cnt", drop_cnt, exp_drop);
    check("t4_drop_12", drop_cnt, 12);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4_clr_overflow", overflow, 0);
    check("t4_clr_drop_cnt", drop_cnt, 0);
    cap_mode = 1'b0;
    m_tready = 1'b1;
    drain("t4_drain");
    check("t4_held", obs.size() - base, 8);

    // enable falling in HI pads; samples while disabled are ignored
    base = obs.size();
    send(0, 7);
    set_en(0);
    send(0, 20); send(0, 21); send(1, 22);
    drain("t5_drain_a");
    check("t5_count", obs.size() - base, 1);
    check("t5_pad7", obs[base], {3'b011, 32'h0000_8007});
    set_en(1);
    send(0, 8); send(0, 9);
    set_en(0);
    drain("t5_drain_b");
    check("t5_after_rise", obs[base+1], {3'b011, 32'h8009_8008});

    // reset mid-packet with FIFO and stage occupied
    set_en(1);
    m_tready = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4); send(0, 5);
    check("t6_pre_tvalid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    check_rst_outputs("t6_rst");
    m_reset();
    m_tready = 1'b1;
    step();
    step();
    rst = 1'b0;
    base = obs.size();
    send(0, 9); send(0, 10);
    set_en(0);
    drain("t6_drain");
    check("t6_count", obs.size() - base, 1);
    check("t6_w0", obs[base], {3'b011, 32'h800A_8009});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
